// File: rtl/snoop_pkt_stats_ctrl.sv
// Passive AXI-Stream packet statistics tap with a record FIFO.
// Optional keep-pattern checking is enabled by defining SNOOP_KEEP_CHECK_EN.
module snoop_pkt_stats_ctrl #(
   parameter int unsigned TDATA_WIDTH = 64,
   parameter int unsigned TKEEP_WIDTH = TDATA_WIDTH/8,
   parameter int unsigned LEN_WIDTH   = 16,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   mon_tvalid,
   input  logic                   mon_tready,
   input  logic [TKEEP_WIDTH-1:0] mon_tkeep,
   input  logic                   mon_tlast,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [LEN_WIDTH-1:0]   rec_len,
   output logic [LEN_WIDTH-1:0]   rec_flits,
   output logic                   rec_err,
   output logic [31:0]            pkt_count,
   output logic [15:0]            drop_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);

   typedef enum logic {
      S_IDLE,
      S_IN_PKT
   } state_t;

   typedef struct packed {
      logic [LEN_WIDTH-1:0] len;
      logic [LEN_WIDTH-1:0] flits;
`ifdef SNOOP_KEEP_CHECK_EN
      logic                 err;
`endif
   } rec_t;

   state_t               state;
   logic [LEN_WIDTH-1:0] acc_len;
   logic [LEN_WIDTH-1:0] acc_flits;

   logic                 beat_acc;
   logic                 pkt_done;
   logic                 in_pkt;
   logic [LEN_WIDTH:0]   beat_bytes;
   logic [LEN_WIDTH:0]   sum_len;
   logic [LEN_WIDTH-1:0] cur_len;
   logic [LEN_WIDTH-1:0] cur_flits;
   logic [LEN_WIDTH-1:0] nxt_len;
   logic [LEN_WIDTH-1:0] nxt_flits;

   rec_t                 push_rec;
   rec_t                 head;
   rec_t                 mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 push_ok;
   logic                 drop;

   assign beat_acc = mon_tvalid & mon_tready;
   assign pkt_done = beat_acc & mon_tlast;
   assign in_pkt   = (state == S_IN_PKT);

   // A beat seen in IDLE always starts from empty accumulators.
   assign cur_len   = in_pkt ? acc_len   : '0;
   assign cur_flits = in_pkt ? acc_flits : '0;

   // Byte count of the current beat is the popcount of keep.
   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < TKEEP_WIDTH; i++) begin
         beat_bytes = beat_bytes + {{LEN_WIDTH{1'b0}}, mon_tkeep[i]};
      end
   end

   // Saturating next-value computation for both accumulators.
   always_comb begin
      sum_len   = {1'b0, cur_len} + beat_bytes;
      nxt_len   = sum_len[LEN_WIDTH] ? '1 : sum_len[LEN_WIDTH-1:0];
      nxt_flits = (&cur_flits) ? cur_flits : cur_flits + LEN_ONE;
   end

`ifdef SNOOP_KEEP_CHECK_EN
   localparam logic [TKEEP_WIDTH-1:0] KEEP_ONE = TKEEP_WIDTH'(1);

   logic                   acc_err;
   logic                   cur_err;
   logic                   nxt_err;
   logic                   beat_err;
   logic                   keep_lo;
   logic                   keep_hi;
   logic [TKEEP_WIDTH-1:0] keep_inv;

   // Legal keep: zero, a run of ones from bit 0, or a run ending at the MSB.
   always_comb begin
      keep_inv = ~mon_tkeep;
      keep_lo  = ((mon_tkeep & (mon_tkeep + KEEP_ONE)) == '0);
      keep_hi  = ((keep_inv & (keep_inv + KEEP_ONE)) == '0);
      beat_err = ~(keep_lo | keep_hi);
      cur_err  = in_pkt & acc_err;
      nxt_err  = cur_err | beat_err;
   end

   // Sticky per-packet error flag.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         acc_err <= 1'b0;
      end else if (beat_acc) begin
         acc_err <= mon_tlast ? 1'b0 : nxt_err;
      end
   end
`endif

   // Packet framing FSM with byte/flit accumulators.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= S_IDLE;
         acc_len   <= '0;
         acc_flits <= '0;
      end else if (beat_acc) begin
         if (mon_tlast) begin
            state     <= S_IDLE;
            acc_len   <= '0;
            acc_flits <= '0;
         end else begin
            state     <= S_IN_PKT;
            acc_len   <= nxt_len;
            acc_flits <= nxt_flits;
         end
      end
   end

   // Record built from the completing beat's totals.
   always_comb begin
      push_rec       = '0;
      push_rec.len   = nxt_len;
      push_rec.flits = nxt_flits;
`ifdef SNOOP_KEEP_CHECK_EN
      push_rec.err   = nxt_err;
`endif
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = rec_valid & rec_ready;
   assign push_ok    = pkt_done & (~fifo_full | pop);
   assign drop       = pkt_done & fifo_full & ~pop;

   // Record FIFO storage; a full-FIFO push with a pop reuses the head slot.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= push_rec;
      end
   end

   // FIFO read/write pointers with wrap bit.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   assign head      = mem[rd_ptr[AW-1:0]];
   assign rec_valid = ~fifo_empty;
   assign rec_len   = rec_valid ? head.len   : '0;
   assign rec_flits = rec_valid ? head.flits : '0;

`ifdef SNOOP_KEEP_CHECK_EN
   assign rec_err   = rec_valid & head.err;
`else
   assign rec_err   = 1'b0;
`endif

   // Completed-packet counter (wraps) and drop counter (saturates).
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         if (pkt_done) begin
            pkt_count <= pkt_count + 32'd1;
         end
         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/snoop_pkt_stats_ctrl.md
SNOOP_PKT_STATS_CTRL -- requirements
Module: snoop_pkt_stats_ctrl

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 64, monitored stream data width in bits.
REQ-002 SHALL have parameter TKEEP_WIDTH, default TDATA_WIDTH/8, keep width in bits.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of packet byte length and flit count fields.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, record FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port mon_tvalid  input  1  tapped stream valid.
REQ-008 SHALL have port mon_tready  input  1  tapped stream ready (observed only, never driven).
REQ-009 SHALL have port mon_tkeep  input  TKEEP_WIDTH  tapped stream keep.
REQ-010 SHALL have port mon_tlast  input  1  tapped stream last.
REQ-011 SHALL have port rec_valid  output  1  packet record available.
REQ-012 SHALL have port rec_ready  input  1  record consumer ready.
REQ-013 SHALL have port rec_len  output  LEN_WIDTH  packet byte count.
REQ-014 SHALL have port rec_flits  output  LEN_WIDTH  packet flit count.
REQ-015 SHALL have port rec_err  output  1  packet contained illegal keep pattern.
REQ-016 SHALL have port pkt_count  output  32  total packets completed (recorded or dropped).
REQ-017 SHALL have port drop_count  output  16  records lost to full FIFO.

Function
REQ-018 SHALL treat a beat as accepted only when mon_tvalid and mon_tready are both 1 on a clock edge; unaccepted beats have no effect.
REQ-019 SHALL compute bytes per accepted beat as the number of set bits in mon_tkeep (0..TKEEP_WIDTH); keep=0 beat counts 0 bytes, 1 flit.
REQ-020 SHALL run FSM IDLE/IN_PKT: IDLE->IN_PKT on accepted beat with tlast=0; IN_PKT->IDLE on accepted beat with tlast=1; accepted tlast=1 beat in IDLE completes a one-flit packet and stays IDLE.
REQ-021 SHALL accumulate byte and flit counts per packet including the tlast beat, clearing both when the packet completes.
REQ-022 SHALL saturate byte and flit accumulators at 2^LEN_WIDTH-1, no wrap.
REQ-023 SHALL push {len, flits, err} into the record FIFO on the edge the tlast beat is accepted; record visible on rec_valid the following cycle (1-cycle latency).
REQ-024 SHALL pop the FIFO head when rec_valid and rec_ready are both 1; rec_len/rec_flits/rec_err stable while rec_valid=1 and rec_ready=0.
REQ-025 SHALL accept a push when FIFO is full only if a pop occurs the same cycle; otherwise discard the record and increment drop_count.
REQ-026 SHALL increment pkt_count on every completed packet (wrapping at 2^32); drop_count SHALL saturate at 16'hFFFF.
REQ-027 SHALL not stall or backpressure the tapped stream under any condition.

Reset
REQ-028 SHALL, on aresetn=0, asynchronously force FSM to IDLE, accumulators to 0, FIFO empty, rec_valid=0, rec_len=0, rec_flits=0, rec_err=0, pkt_count=0, drop_count=0.
REQ-029 SHALL discard any partially accumulated packet on reset; first accepted beat after release starts a new packet.

Configuration
REQ-030 SHALL, with macro SNOOP_KEEP_CHECK_EN defined, flag keep patterns other than 0, contiguous-from-bit-0, or contiguous-ending-at-MSB as illegal, setting the packet's sticky err bit (bytes still counted by popcount).
REQ-031 SHALL, without SNOOP_KEEP_CHECK_EN, tie rec_err to 0 and omit the check logic.

Verification
REQ-032 SHALL cover: 3 beats keep FF,FF,0F with tlast on third -> one record len=20, flits=3, err=0, rec_valid one cycle after third beat.
REQ-033 SHALL cover: single beat keep 80, tlast=1, from IDLE -> record len=1, flits=1; pkt_count=1.
REQ-034 SHALL cover: rec_ready=0, 5 one-flit packets keep FF (FIFO_DEPTH=4) -> 4 records len=8 retained, drop_count=1, pkt_count=5.
REQ-035 SHALL cover: with SNOOP_KEEP_CHECK_EN, beats keep 5A then FF tlast -> len=12, flits=2, err=1; next clean packet err=0.
REQ-036 SHALL cover: aresetn asserted after 2 non-last beats, released, then one beat keep 03 tlast -> single record len=2, flits=1, no record for aborted packet.
